instr_fetch_unit: RTL and testbench
===================================

# instr_fetch_unit

Fetch stage feeding the instruction decoder. Holds the fetch PC, issues single-word reads to instruction memory over a request/response handshake, and latches the returned word into an instruction register. It presents the full instruction, the opcode field and the instruction's PC downstream under a valid/ready handshake. It accepts PC redirects from branch/jump resolution and discards in-flight fetches made stale by them.

## Interface
Parameters:
- RESET_PC, 32'h0000_1000: first fetch address after reset.
- NOP_INSTR, 32'h0000_0013: instruction register contents at reset (addi x0,x0,0).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- imem_req  out  1  single-cycle read request pulse.
- imem_addr  out  32  read address; valid when imem_req=1.
- imem_rvalid  in  1  read data valid (≥1 cycle after request).
- imem_rdata  in  32  read data.
- instr_valid  out  1  instr/op/pc hold a fetched instruction.
- instr_ready  in  1  downstream accepts the instruction.
- instr  out  32  instruction register.
- op  out  7  instr[6:0]; drives the decoder's op input.
- pc  out  32  address of the instruction in instr.
- pc_plus4  out  32  pc + 4, mod 2^32.
- pc_load  in  1  redirect request.
- pc_target  in  32  redirect address.
- fault  out  1  sticky misaligned-redirect flag (tied 0 unless the macro is defined).

## Operation
- States: FETCH, WAIT, HOLD, FAULT (FAULT exists only with the macro).
- Reset values: state=FETCH, fetch_pc=RESET_PC, imem_req=0, instr_valid=0, instr=NOP_INSTR, pc=RESET_PC, drop=0, fault=0.
- FETCH: imem_req=1 and imem_addr=fetch_pc combinationally for one cycle. Next state is WAIT.
- WAIT: imem_req=0. On imem_rvalid with drop=0: instr<=imem_rdata, pc<=fetch_pc, instr_valid<=1, next state HOLD. On imem_rvalid with drop=1: drop<=0, data discarded, next state FETCH.
- HOLD: instr, op and pc stay stable while instr_valid=1 && instr_ready=0. On a handshake: instr_valid<=0, fetch_pc<=fetch_pc+4 (wraps 32'hFFFF_FFFC→0), next state FETCH.
- pc_load has priority over everything else, in any state:
  - fetch_pc<=pc_target.
  - In WAIT without rvalid: drop<=1, stay in WAIT.
  - In WAIT with rvalid in the same cycle: data discarded, next state FETCH.
  - In HOLD: instr_valid<=0, next state FETCH. A handshake in the same cycle counts as completed, but the +4 increment is suppressed.
  - In FETCH: the request still issues to the old fetch_pc. It is marked drop=1 and the FSM goes to WAIT.
- imem_rvalid outside WAIT is ignored.
- instr and pc keep their last values when instr_valid=0.
- No more than one read is outstanding at any time.

## Timing
- Zero-wait memory (rvalid one cycle after req): req in cycle N, capture in cycle N+1, instr_valid=1 from cycle N+2.
- Handshake in N+2 puts the next req in cycle N+3. Peak throughput is 1 instruction per 3 cycles.
- Redirect: pc_load in cycle M puts req at pc_target in cycle M+1 (from HOLD or WAIT+rvalid). Otherwise the req goes out in the cycle after the stale response returns.
- op, pc_plus4 and imem_addr are combinational from registers. There is no combinational path from instr_ready or pc_load to any output.

## Configuration
- FETCH_ALIGN_CHECK_EN defined:
  - pc_load with pc_target[1:0]≠0 sets fault<=1, instr_valid<=0 and state<=FAULT. fetch_pc is not updated.
  - FAULT issues no requests, ignores all inputs, and is left only by reset.
- Undefined: pc_target[1:0] is forced to 2'b00 on load, fault is tied 0 and there is no FAULT state.

## Test plan
- Reset, zero-wait memory returning 32'h00500093 at 0x1000 -> req addr 0x1000 in cycle 0, instr_valid in cycle 2, op=7'b0010011, pc=0x1000, pc_plus4=0x1004.
- instr_ready held 0 for 5 cycles -> instr/pc stable, no new req. Ready=1 -> next req addr 0x1004 the following cycle.
- 3-cycle memory latency, pc_load to 0x2000 in WAIT -> stale response dropped (instr_valid stays 0), next req addr 0x2000.
- pc_load to 0x3000 coincident with handshake in HOLD -> next req addr 0x3000, not pc+4.
- fetch_pc=32'hFFFF_FFFC handshake -> next req addr 0x0000_0000.
- With FETCH_ALIGN_CHECK_EN: pc_load target 0x2002 -> fault=1 next cycle, no further imem_req until reset. Without the macro: next req addr 0x2000.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: fetch PC, single-outstanding imem read, instruction register with valid/ready output.
// Optional misaligned-redirect trap enabled by defining FETCH_ALIGN_CHECK_EN.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_1000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [6:0]  op,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  input  logic        pc_load,
  input  logic [31:0] pc_target,
  output logic        fault
);

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    WAIT  = 2'd1,
    HOLD  = 2'd2
`ifdef FETCH_ALIGN_CHECK_EN
    , FAULT = 2'd3
`endif
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc_q, pc_d;
  logic        valid_q, valid_d;
  logic        drop_q, drop_d;
  logic [31:0] tgt_s;

`ifdef FETCH_ALIGN_CHECK_EN
  logic fault_q, fault_d;
  logic misalign_s;
  assign tgt_s      = pc_target;
  assign misalign_s = pc_load && (pc_target[1:0] != 2'b00);
  assign fault      = fault_q;
`else
  assign tgt_s = pc_target & 32'hFFFF_FFFC;
  assign fault = 1'b0;
`endif

  // Request is held off during reset so the reset value of imem_req is 0.
  assign imem_req    = (state_q == FETCH) && !reset;
  assign imem_addr   = fetch_pc_q;
  assign instr_valid = valid_q;
  assign instr       = instr_q;
  assign op          = instr_q[6:0];
  assign pc          = pc_q;
  assign pc_plus4    = pc_q + 32'd4;

  // Next-state logic: redirects take priority over responses and handshakes.
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    instr_d    = instr_q;
    pc_d       = pc_q;
    valid_d    = valid_q;
    drop_d     = drop_q;
`ifdef FETCH_ALIGN_CHECK_EN
    fault_d    = fault_q;
`endif
    case (state_q)
      FETCH: begin
        state_d = WAIT;
        if (pc_load) begin
          fetch_pc_d = tgt_s;
          drop_d     = 1'b1;
        end else begin
          drop_d     = 1'b0;
        end
      end
      WAIT: begin
        if (pc_load) begin
          fetch_pc_d = tgt_s;
          if (imem_rvalid) begin
            drop_d  = 1'b0;
            state_d = FETCH;
          end else begin
            drop_d  = 1'b1;
          end
        end else if (imem_rvalid) begin
          if (drop_q) begin
            drop_d  = 1'b0;
            state_d = FETCH;
          end else begin
            instr_d = imem_rdata;
            pc_d    = fetch_pc_q;
            valid_d = 1'b1;
            state_d = HOLD;
          end
        end else begin
          state_d = WAIT;
        end
      end
      HOLD: begin
        // A handshake coinciding with a redirect completes, but the +4 is skipped.
        if (pc_load) begin
          fetch_pc_d = tgt_s;
          valid_d    = 1'b0;
          state_d    = FETCH;
        end else if (instr_ready) begin
          fetch_pc_d = fetch_pc_q + 32'd4;
          valid_d    = 1'b0;
          state_d    = FETCH;
        end else begin
          state_d    = HOLD;
        end
      end
`ifdef FETCH_ALIGN_CHECK_EN
      FAULT: begin
        state_d = FAULT;
      end
`endif
      default: begin
        state_d = FETCH;
        valid_d = 1'b0;
        drop_d  = 1'b0;
      end
    endcase
`ifdef FETCH_ALIGN_CHECK_EN
    // A misaligned redirect freezes the unit until reset; fetch_pc is left untouched.
    if (misalign_s && (state_q != FAULT)) begin
      fault_d    = 1'b1;
      valid_d    = 1'b0;
      drop_d     = 1'b0;
      fetch_pc_d = fetch_pc_q;
      state_d    = FAULT;
    end else begin
      fault_d    = fault_q;
    end
`endif
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= FETCH;
      fetch_pc_q <= RESET_PC;
      instr_q    <= NOP_INSTR;
      pc_q       <= RESET_PC;
      valid_q    <= 1'b0;
      drop_q     <= 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
      fault_q    <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      instr_q    <= instr_d;
      pc_q       <= pc_d;
      valid_q    <= valid_d;
      drop_q     <= drop_d;
`ifdef FETCH_ALIGN_CHECK_EN
      fault_q    <= fault_d;
`endif
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: directed scenarios plus randomized traffic against an event-level model.
// Honors FETCH_ALIGN_CHECK_EN in the same way as the design.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [6:0]  op;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        pc_load;
  logic [31:0] pc_target;
  logic        fault;

  instr_fetch_unit dut (
    .clk(clk), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .op(op), .pc(pc), .pc_plus4(pc_plus4),
    .pc_load(pc_load), .pc_target(pc_target), .fault(fault)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Architectural view: where the next fetch goes, whether a read is in flight
  // (and whether a redirect made it stale), and what instruction is presented.
  logic [31:0] m_fetch, m_instr, m_pc;
  logic        m_req_due, m_out, m_stale, m_valid, m_fault;

  // Memory: answers each request after 'lat' cycles with memfn(addr).
  logic        mem_pend;
  int          mem_cnt;
  logic [31:0] mem_addr;
  int          lat;
  logic        spur_en;

  function automatic logic [31:0] memfn(input logic [31:0] a);
    if (a == 32'h0000_1000) return 32'h0050_0093;
    return {a[15:0], a[31:16]} ^ 32'hA5C3_0013;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_fetch   = 32'h0000_1000;
    m_instr   = 32'h0000_0013;
    m_pc      = 32'h0000_1000;
    m_req_due = 1'b1;
    m_out     = 1'b0;
    m_stale   = 1'b0;
    m_valid   = 1'b0;
    m_fault   = 1'b0;
    mem_pend  = 1'b0;
    mem_cnt   = 0;
    mem_addr  = 32'd0;
  endtask

  // One clock cycle: compare outputs to the model, drive inputs, advance the model.
  task automatic step(input logic ld, input logic [31:0] tgt, input logic rdy);
    logic        rv;
    logic [31:0] rd, te;
    logic        mis;
    check_eq("imem_req", {31'd0, imem_req}, {31'd0, m_req_due});
    if (m_req_due) check_eq("imem_addr", imem_addr, m_fetch);
    check_eq("instr_valid", {31'd0, instr_valid}, {31'd0, m_valid});
    check_eq("instr", instr, m_instr);
    check_eq("pc", pc, m_pc);
    check_eq("op", {25'd0, op}, {25'd0, m_instr[6:0]});
    check_eq("pc_plus4", pc_plus4, m_pc + 32'd4);
    check_eq("fault", {31'd0, fault}, {31'd0, m_fault});

    rv = 1'b0;
    rd = $urandom;
    if (mem_pend) begin
      mem_cnt--;
      if (mem_cnt == 0) begin
        rv = 1'b1;
        rd = memfn(mem_addr);
        mem_pend = 1'b0;
      end
    end else if (spur_en && ($urandom_range(0, 9) == 0)) begin
      rv = 1'b1;
    end
    if (imem_req) begin
      mem_pend = 1'b1;
      mem_cnt  = lat;
      mem_addr = imem_addr;
    end

    pc_load     = ld;
    pc_target   = tgt;
    instr_ready = rdy;
    imem_rvalid = rv;
    imem_rdata  = rd;

`ifdef FETCH_ALIGN_CHECK_EN
    te  = tgt;
    mis = ld && (te[1:0] != 2'b00);
`else
    te  = tgt & 32'hFFFF_FFFC;
    mis = 1'b0;
`endif

    if (m_fault) begin
      m_req_due = 1'b0;
    end else if (mis) begin
      m_fault = 1'b1; m_valid = 1'b0; m_req_due = 1'b0; m_out = 1'b0;
    end else if (m_req_due) begin
      m_req_due = 1'b0;
      m_out     = 1'b1;
      m_stale   = ld;
      if (ld) m_fetch = te;
    end else if (m_out) begin
      if (ld) m_fetch = te;
      if (rv) begin
        m_out = 1'b0;
        if (m_stale || ld) begin
          m_req_due = 1'b1;
        end else begin
          m_valid = 1'b1; m_instr = rd; m_pc = m_fetch;
        end
      end else if (ld) begin
        m_stale = 1'b1;
      end
    end else if (m_valid) begin
      if (ld) begin
        m_valid = 1'b0; m_fetch = te; m_req_due = 1'b1;
      end else if (rdy) begin
        m_valid = 1'b0; m_fetch = m_fetch + 32'd4; m_req_due = 1'b1;
      end
    end

    @(posedge clk);
    #1;
  endtask

  task automatic run_until_valid(input int budget);
    int n = 0;
    while (!instr_valid && (n < budget)) begin
      step(1'b0, 32'd0, 1'b0);
      n++;
    end
    check_eq("valid_timeout", {31'd0, instr_valid}, 32'd1);
  endtask

  initial begin
    reset = 1'b1; imem_rvalid = 1'b0; imem_rdata = 32'd0;
    instr_ready = 1'b0; pc_load = 1'b0; pc_target = 32'd0;
    lat = 1; spur_en = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_req", {31'd0, imem_req}, 32'd0);
    check_eq("rst_valid", {31'd0, instr_valid}, 32'd0);
    check_eq("rst_instr", instr, 32'h0000_0013);
    check_eq("rst_pc", pc, 32'h0000_1000);
    check_eq("rst_fault", {31'd0, fault}, 32'd0);
    reset = 1'b0;
    model_reset();
    #1;

    // Zero-wait fetch of 0x1000, then back-pressure.
    check_eq("t1_req", {31'd0, imem_req}, 32'd1);
    check_eq("t1_addr", imem_addr, 32'h0000_1000);
    step(1'b0, 32'd0, 1'b0);
    step(1'b0, 32'd0, 1'b0);
    check_eq("t1_valid", {31'd0, instr_valid}, 32'd1);
    check_eq("t1_op", {25'd0, op}, 32'h0000_0013);
    check_eq("t1_pc", pc, 32'h0000_1000);
    check_eq("t1_pc4", pc_plus4, 32'h0000_1004);
    repeat (5) step(1'b0, 32'd0, 1'b0);
    check_eq("t2_instr", instr, 32'h0050_0093);
    check_eq("t2_pc", pc, 32'h0000_1000);
    check_eq("t2_noreq", {31'd0, imem_req}, 32'd0);
    step(1'b0, 32'd0, 1'b1);
    check_eq("t2_req", {31'd0, imem_req}, 32'd1);
    check_eq("t2_addr", imem_addr, 32'h0000_1004);

    // 3-cycle latency with a redirect while waiting.
    lat = 3;
    step(1'b0, 32'd0, 1'b0);
    step(1'b1, 32'h0000_2000, 1'b0);
    step(1'b0, 32'd0, 1'b0);
    step(1'b0, 32'd0, 1'b0);
    check_eq("t3_valid", {31'd0, instr_valid}, 32'd0);
    check_eq("t3_req", {31'd0, imem_req}, 32'd1);
    check_eq("t3_addr", imem_addr, 32'h0000_2000);

    // Redirect coinciding with a handshake.
    lat = 1;
    run_until_valid(10);
    step(1'b1, 32'h0000_3000, 1'b1);
    check_eq("t4_req", {31'd0, imem_req}, 32'd1);
    check_eq("t4_addr", imem_addr, 32'h0000_3000);

    // Fetch PC wrap at the top of the address space.
    run_until_valid(10);
    step(1'b1, 32'hFFFF_FFFC, 1'b0);
    check_eq("t5_addr", imem_addr, 32'hFFFF_FFFC);
    run_until_valid(10);
    check_eq("t5_pc", pc, 32'hFFFF_FFFC);
    check_eq("t5_pc4", pc_plus4, 32'h0000_0000);
    step(1'b0, 32'd0, 1'b1);
    check_eq("t5_req", {31'd0, imem_req}, 32'd1);
    check_eq("t5_wrap", imem_addr, 32'h0000_0000);

    // Randomized traffic: latency, back-pressure, redirects, stray responses.
    spur_en = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] t;
      lat = $urandom_range(1, 3);
      t = $urandom;
`ifdef FETCH_ALIGN_CHECK_EN
      t = t & 32'hFFFF_FFFC;
`endif
      step(($urandom_range(0, 11) == 0), t, 1'($urandom_range(0, 1)));
    end
    spur_en = 1'b0;
    lat = 1;
    run_until_valid(20);

    // Misaligned redirect target.
    step(1'b1, 32'h0000_2002, 1'b0);
`ifdef FETCH_ALIGN_CHECK_EN
    check_eq("t6_fault", {31'd0, fault}, 32'd1);
    check_eq("t6_valid", {31'd0, instr_valid}, 32'd0);
    for (int i = 0; i < 10; i++) begin
      check_eq("t6_noreq", {31'd0, imem_req}, 32'd0);
      step(1'($urandom_range(0, 1)), 32'h0000_4000, 1'($urandom_range(0, 1)));
    end
`else
    check_eq("t6_fault", {31'd0, fault}, 32'd0);
    check_eq("t6_req", {31'd0, imem_req}, 32'd1);
    check_eq("t6_addr", imem_addr, 32'h0000_2000);
    repeat (4) step(1'b0, 32'd0, 1'b1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
